// File: rtl/stage_buffer.sv
// rtl/stage_buffer.sv - DEPTH-entry elastic valid/ready buffer between pipeline stages with one-cycle flush
module stage_buffer #(
    parameter int DATA_W = 96,
    parameter int DEPTH  = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_ro,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_ro,
    input  logic              flush_i,
    output logic [CNT_W-1:0]  count_o
);

    // A single-entry buffer still needs a 1-bit pointer so the array index is legal.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;

    // Explicit wrap so non-power-of-two depths cycle through exactly DEPTH slots.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Handshake outputs come from registered state only, so neither side sees a
    // combinational path from the other. A full buffer refuses a push even when a
    // pop happens in the same cycle.
    assign ready_o  = (count != FULL_CNT);
    assign valid_ro = (count != '0);
    assign data_ro  = valid_ro ? mem[rd_ptr] : '0;
    assign count_o  = count;

    // A flush cycle performs no transfer in either direction.
    assign push = valid_i & ready_o & ~flush_i;
    assign pop  = valid_ro & ready_i & ~flush_i;

    // Pointer and occupancy state; flush empties the buffer without touching mem.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: data_ro is masked to zero whenever count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_i;
        end
    end

endmodule

// File: tb/tb_stage_buffer.sv
// tb/tb_stage_buffer.sv - directed self-checking bench for stage_buffer at depths 4, 3, 2 and 1
module tb_stage_buffer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // DEPTH = 4 instance
    logic       v4 = 0, r4 = 0, f4 = 0;
    logic [7:0] d4 = 0;
    logic       rdy4, vo4;
    logic [7:0] q4;
    logic [2:0] c4;
    // DEPTH = 3 instance
    logic       v3 = 0, r3 = 0, f3 = 0;
    logic [7:0] d3 = 0;
    logic       rdy3, vo3;
    logic [7:0] q3;
    logic [1:0] c3;
    // DEPTH = 2 instance
    logic       v2 = 0, r2 = 0, f2 = 0;
    logic [7:0] d2 = 0;
    logic       rdy2, vo2;
    logic [7:0] q2;
    logic [1:0] c2;
    // DEPTH = 1 instance
    logic       v1 = 0, r1 = 0, f1 = 0;
    logic [7:0] d1 = 0;
    logic       rdy1, vo1;
    logic [7:0] q1;
    logic [0:0] c1;

    stage_buffer #(.DATA_W(8), .DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .valid_i(v4), .ready_o(rdy4), .data_i(d4),
        .valid_ro(vo4), .ready_i(r4), .data_ro(q4), .flush_i(f4), .count_o(c4));
    stage_buffer #(.DATA_W(8), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .valid_i(v3), .ready_o(rdy3), .data_i(d3),
        .valid_ro(vo3), .ready_i(r3), .data_ro(q3), .flush_i(f3), .count_o(c3));
    stage_buffer #(.DATA_W(8), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .valid_i(v2), .ready_o(rdy2), .data_i(d2),
        .valid_ro(vo2), .ready_i(r2), .data_ro(q2), .flush_i(f2), .count_o(c2));
    stage_buffer #(.DATA_W(8), .DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .valid_i(v1), .ready_o(rdy1), .data_i(d1),
        .valid_ro(vo1), .ready_i(r1), .data_ro(q1), .flush_i(f1), .count_o(c1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // power-on reset values
        #1;
        checks++; if (vo4 !== 1'b0)  begin failures++; $display("FAIL por_valid got=%0h exp=0", vo4); end
        checks++; if (rdy4 !== 1'b1) begin failures++; $display("FAIL por_ready got=%0h exp=1", rdy4); end
        checks++; if (c4 !== 3'd0)   begin failures++; $display("FAIL por_count got=%0d exp=0", c4); end
        checks++; if (q4 !== 8'h00)  begin failures++; $display("FAIL por_data got=%0h exp=0", q4); end
        rst = 1'b1;
        step();
        // mid-stream reset with two entries held
        v4 = 1; r4 = 0; d4 = 8'h01; step();
        d4 = 8'h02; step();
        v4 = 0;
        checks++; if (c4 !== 3'd2) begin failures++; $display("FAIL pre_rst_count got=%0d exp=2", c4); end
        #2 rst = 1'b0;
        #1;
        checks++; if (vo4 !== 1'b0)  begin failures++; $display("FAIL rst_valid got=%0h exp=0", vo4); end
        checks++; if (rdy4 !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0h exp=1", rdy4); end
        checks++; if (c4 !== 3'd0)   begin failures++; $display("FAIL rst_count got=%0d exp=0", c4); end
        checks++; if (q4 !== 8'h00)  begin failures++; $display("FAIL rst_data got=%0h exp=0", q4); end
        #1 rst = 1'b1;
        step();
        v4 = 1; d4 = 8'hA5;
        checks++; if (vo4 !== 1'b0) begin failures++; $display("FAIL no_bypass got=%0h exp=0", vo4); end
        step();
        v4 = 0;
        checks++; if (vo4 !== 1'b1 || q4 !== 8'hA5) begin failures++; $display("FAIL first_push got=%0h/%0h exp=1/a5", vo4, q4); end
        r4 = 1; step(); r4 = 0;
        checks++; if (c4 !== 3'd0) begin failures++; $display("FAIL post_rst_drain got=%0d exp=0", c4); end
    endtask

    task automatic test_fill_drain();
        logic [7:0] pay [4];
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
        r4 = 0;
        for (int i = 0; i < 4; i++) begin
            v4 = 1; d4 = pay[i]; step();
            checks++; if (c4 !== 3'(i + 1)) begin failures++; $display("FAIL fill_count%0d got=%0d exp=%0d", i, c4, i + 1); end
        end
        checks++; if (rdy4 !== 1'b0) begin failures++; $display("FAIL full_ready got=%0h exp=0", rdy4); end
        d4 = 8'h55; step();
        v4 = 0;
        checks++; if (c4 !== 3'd4) begin failures++; $display("FAIL refuse_55 got=%0d exp=4", c4); end
        r4 = 1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (vo4 !== 1'b1 || q4 !== pay[i]) begin failures++; $display("FAIL drain%0d got=%0h/%0h exp=1/%0h", i, vo4, q4, pay[i]); end
            step();
        end
        r4 = 0;
        checks++; if (vo4 !== 1'b0) begin failures++; $display("FAIL drained_valid got=%0h exp=0", vo4); end
    endtask

    task automatic test_wrap();
        int sent = 0;
        int rcvd = 0;
        int cyc  = 0;
        while (rcvd < 10 && cyc < 300) begin
            v3 = (sent < 10) && ($urandom_range(0, 2) != 0);
            d3 = 8'(sent + 1);
            r3 = ($urandom_range(0, 2) != 0);
            if (vo3 && r3) begin
                checks++; if (q3 !== 8'(rcvd + 1)) begin failures++; $display("FAIL wrap_data got=%0d exp=%0d", q3, rcvd + 1); end
                rcvd++;
            end
            if (v3 && rdy3) sent++;
            step();
            cyc++;
            if (c3 > 2'd3 || $isunknown(c3)) begin checks++; failures++; $display("FAIL wrap_count got=%0d exp<=3", c3); end
        end
        v3 = 0; r3 = 0;
        checks++; if (rcvd != 10) begin failures++; $display("FAIL wrap_total got=%0d exp=10", rcvd); end
        checks++; if (vo3 !== 1'b0) begin failures++; $display("FAIL wrap_empty got=%0h exp=0", vo3); end
    endtask

    task automatic test_full_pop();
        r2 = 0; v2 = 1;
        d2 = 8'd1; step();
        d2 = 8'd2; step();
        checks++; if (c2 !== 2'd2) begin failures++; $display("FAIL d2_full got=%0d exp=2", c2); end
        d2 = 8'd3; r2 = 1; step();
        checks++; if (c2 !== 2'd1 || q2 !== 8'd2) begin failures++; $display("FAIL full_pop got=%0d/%0h exp=1/2", c2, q2); end
        for (int k = 3; k < 7; k++) begin
            d2 = 8'(k); step();
            checks++; if (c2 !== 2'd1 || q2 !== 8'(k)) begin failures++; $display("FAIL stream%0d got=%0d/%0h exp=1/%0h", k, c2, q2, k); end
        end
        v2 = 0; step(); r2 = 0;
    endtask

    task automatic test_flush();
        r4 = 0; v4 = 1;
        d4 = 8'h01; step();
        d4 = 8'h02; step();
        d4 = 8'h03; step();
        checks++; if (c4 !== 3'd3) begin failures++; $display("FAIL pre_flush got=%0d exp=3", c4); end
        d4 = 8'h99; r4 = 1; f4 = 1; step();
        f4 = 0; v4 = 0; r4 = 0;
        checks++; if (c4 !== 3'd0 || vo4 !== 1'b0 || rdy4 !== 1'b1) begin failures++; $display("FAIL flush got=%0d/%0h/%0h exp=0/0/1", c4, vo4, rdy4); end
        v4 = 1; d4 = 8'h77; step(); v4 = 0;
        checks++; if (c4 !== 3'd1 || q4 !== 8'h77) begin failures++; $display("FAIL after_flush got=%0d/%0h exp=1/77", c4, q4); end
        r4 = 1; step(); r4 = 0;
        checks++; if (vo4 !== 1'b0) begin failures++; $display("FAIL no_99 got=%0h/%0h exp=0", vo4, q4); end
    endtask

    task automatic test_depth1();
        int pops  = 0;
        int pushd = 0;
        v1 = 1; r1 = 1; d1 = 8'd1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            logic pu, po;
            pu = rdy1;
            po = vo1;
            if (po) begin
                checks++; if (q1 !== 8'(pops + 1)) begin failures++; $display("FAIL d1_data got=%0d exp=%0d", q1, pops + 1); end
                pops++;
            end
            if (pu && po) begin checks++; failures++; $display("FAIL d1_overlap got=1 exp=0 cyc=%0d", cyc); end
            step();
            if (pu) begin pushd++; d1 = 8'(pushd + 1); end
        end
        v1 = 0; r1 = 0;
        checks++; if (pops != 4) begin failures++; $display("FAIL d1_rate got=%0d exp=4", pops); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_pop();
        test_flush();
        test_depth1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stage_buffer.md
# stage_buffer

Parametrised elastic buffer that sits between two pipeline stages of the core (fetch→insm, insm→decode, decode→execute, …) on the valid/ready handshake. It generalises the single-entry stage register to DEPTH entries of DATA_W bits. It also adds a flush input, driven from the execute stage's jump-taken signal, that discards every buffered entry in one cycle. Both sides are fully registered: there is no combinational path from ready_i to ready_o, or from valid_i to valid_ro.

## Interface
- DATA_W, default 96: payload width (e.g. pc + inst + r0data).
- DEPTH, default 2: number of entries; any integer ≥ 1 (power of two not required).
- CNT_W, default $clog2(DEPTH+1): width of count_o; derived, not overridden.

Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset; active-low.
- valid_i  in  1  upstream has a payload on data_i.
- ready_o  out  1  buffer can accept a payload this cycle.
- data_i  in  DATA_W  upstream payload.
- valid_ro  out  1  data_ro holds the oldest buffered payload.
- ready_i  in  1  downstream accepts data_ro this cycle.
- data_ro  out  DATA_W  oldest payload; all-zero when empty.
- flush_i  in  1  discard all entries (jump taken).
- count_o  out  CNT_W  number of valid entries, 0..DEPTH.

## Operation
Storage and state:
- Storage is a circular array mem[0..DEPTH-1].
- wr_ptr and rd_ptr each have width $clog2(DEPTH), minimum 1.
- count is a register, 0..DEPTH.

Handshake signals:
- ready_o = (count != DEPTH). It depends on state only.
- valid_ro = (count != 0).
- data_ro = mem[rd_ptr] when count != 0, else 0.

Transfers:
- push = valid_i & ready_o & ~flush_i. On a push, mem[wr_ptr] ← data_i and wr_ptr advances.
- pop = valid_ro & ready_i & ~flush_i. On a pop, rd_ptr advances.
- Pointer advance: if ptr == DEPTH-1 the next value is 0, else ptr+1. No reliance on power-of-two wrap.
- count update: push only → +1; pop only → −1; push and pop together → unchanged; neither → unchanged.
- Ordering is strictly FIFO.

Flush:
- On flush_i = 1 at an edge: count ← 0, wr_ptr ← 0, rd_ptr ← 0.
- A concurrent valid_i is dropped and a concurrent ready_i consumes nothing.
- mem contents need not be cleared.
- Downstream must ignore any valid_ro/ready_i handshake in a flush cycle; the stage driving flush_i owns that rule.

Boundary conditions:
- Full (count == DEPTH): ready_o = 0. A push is refused even if a pop happens in the same cycle, because ready_o does not look at ready_i.
- Consequence for throughput: DEPTH = 1 gives at most one transfer every 2 cycles; DEPTH ≥ 2 sustains 1 transfer/cycle.
- Empty (count == 0): valid_ro = 0 and pop is impossible.
- Push into an empty buffer becomes visible on data_ro the following cycle; there is no bypass.
- Reset mid-operation: all state is cleared asynchronously and outputs go to reset values immediately. Anything in flight is lost.

## Timing
Reset values:
- valid_ro = 0, ready_o = 1, data_ro = 0, count_o = 0.
- wr_ptr = rd_ptr = 0.

Latency and cadence:
- Latency: a payload accepted at edge N is presented on data_ro with valid_ro = 1 after edge N. That is 1 cycle minimum; it is longer if older entries are queued ahead of it.
- ready_o, valid_ro and count_o change only after a clock edge or on reset assertion.
- Flush takes effect at the edge where flush_i = 1. From the next cycle: valid_ro = 0, ready_o = 1, count_o = 0.
- Steady state with DEPTH ≥ 2, valid_i = ready_i = 1: count stays constant and one payload moves per cycle.

## Test plan
- Reset: assert rst = 0 mid-stream with count = 2 → immediately valid_ro = 0, ready_o = 1, count_o = 0, data_ro = 0. After release, the first push of 0xA5 appears one cycle later.
- Fill and drain, DEPTH = 4:
  - Push 0x11, 0x22, 0x33, 0x44 with ready_i = 0 → count_o = 4 and ready_o = 0 after the 4th edge; a 5th payload 0x55 is not accepted.
  - Then set ready_i = 1 → outputs 0x11, 0x22, 0x33, 0x44 on consecutive cycles, then valid_ro = 0.
- Wrap-around, DEPTH = 3: push and pop 10 payloads 1..10 with random valid_i/ready_i stalls → output sequence is exactly 1..10 with no loss or duplication, and count_o never exceeds 3.
- Full with simultaneous pop, DEPTH = 2: count = 2, valid_i = ready_i = 1 → the pop occurs and the push is refused, so count_o = 1 next cycle. Continuous streaming after that gives 1 transfer/cycle.
- Flush, DEPTH = 4: count = 3, and flush_i = 1 with valid_i = 1 (0x99) and ready_i = 1 in the same cycle → next cycle count_o = 0, valid_ro = 0, ready_o = 1. 0x99 never appears; the next push 0x77 is the first output.
- DEPTH = 1: continuous valid_i = ready_i = 1 → exactly one transfer every 2 cycles, with data order preserved.
